pipe_adder: RTL

- Parametrised, pipelined successor to the team's 4-bit ripple-carry full adder.
- Computes WIDTH-bit add or subtract with carry-in, carry-out and signed overflow.
- The carry chain is split into STAGES registered segments so wide adds close timing; full throughput is one operation per clock.
- Sits between datapath producers and consumers behind a valid/ready handshake.

---
 rtl/pipe_adder_if.sv | 30 +++
 rtl/pipe_adder.sv | 100 ++++++++++
 2 files changed

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for pipe_adder.
//   in_valid/in_ready    operand bundle handshake (a, b, c_in, sub)
//   out_valid/out_ready  result bundle handshake (sum, c_out, ovf)
//   master: producer/consumer side (drives operands and out_ready)
//   slave : adder side (drives in_ready and the result bundle)
interface pipe_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit add/subtract with carry-in, carry-out and
// signed overflow. The carry chain is cut into STAGES segments of
// WIDTH/STAGES bits, one segment per register stage; latency is STAGES
// cycles and throughput one operation per clock.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pipe_adder_if.slave
//            in:  in_valid, a, b, c_in (add only), sub, out_ready
//            out: in_ready, out_valid, sum, c_out, ovf
module pipe_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_adder_if.slave   bus
);

  localparam int unsigned SEG = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipe_adder: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // One pipeline stage. a/b hold the full operand word; the slices above
  // the current segment are the not-yet-summed skewed operands, and the MSBs
  // ride along to the last stage for the overflow decision. sum holds the
  // result slices produced so far, so all segments leave aligned.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];
  stage_t in_stage;
  logic   advance;

  // Adds segment k of src.a/src.b with src.carry, filling that slice of sum.
  function automatic stage_t seg_add(input stage_t src, input int unsigned k);
    stage_t     r;
    logic [SEG:0] s;
    r = src;
    s = {1'b0, src.a[k*SEG +: SEG]} + {1'b0, src.b[k*SEG +: SEG]}
      + {{SEG{1'b0}}, src.carry};
    r.sum[k*SEG +: SEG] = s[SEG-1:0];
    r.carry             = s[SEG];
    return r;
  endfunction

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign advance = !stage_q[STAGES-1].valid || bus.out_ready;

  // Bubbles enter with zeroed data so idle outputs never carry stale or X data.
  always_comb begin
    in_stage = '0;
    if (bus.in_valid) begin
      in_stage.valid = 1'b1;
      in_stage.carry = bus.sub | bus.c_in;
      in_stage.a     = bus.a;
      in_stage.b     = bus.sub ? ~bus.b : bus.b;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (advance) begin
      stage_d[0] = seg_add(in_stage, 0);
      for (int unsigned k = 1; k < STAGES; k++) begin
        stage_d[k] = seg_add(stage_q[k-1], k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = stage_q[STAGES-1].valid;
  assign bus.sum       = stage_q[STAGES-1].sum;
  assign bus.c_out     = stage_q[STAGES-1].carry;
  assign bus.ovf       = (stage_q[STAGES-1].a[WIDTH-1] == stage_q[STAGES-1].b[WIDTH-1])
                      && (stage_q[STAGES-1].sum[WIDTH-1] != stage_q[STAGES-1].a[WIDTH-1]);

endmodule
